// File: rtl/count_mod_n.sv
// count_mod_n: parametrised up/down counter with programmable terminal value,
// wrap or saturate behaviour, enable prescaler, terminal-count flag, one-cycle
// carry pulse for cascading, sticky overflow flag and a tri-state count bus.
module count_mod_n #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter int               PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             load_l,
    input  logic             enable_l,
    input  logic             up_dn,
    input  logic             sat_l,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             oe_l,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_tri,
    output logic             tc,
    output logic             carry,
    output logic             ovf
);

    // Prescaler needs at least one bit even when it never leaves zero.
    localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             tick;

    // Next-state logic: load has priority over counting; a step happens only
    // on the enabled cycle where the prescaler reaches its last value.
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        tick    = !enable_l && (presc_q == PS_LAST);
        if (!load_l) begin
            count_d = (cnt_in > MAX_VAL) ? MAX_VAL : cnt_in;
            presc_d = '0;
            ovf_d   = 1'b0;
        end else if (!enable_l) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                if (up_dn) begin
                    if (count_q > MAX_VAL) begin
                        // Only reachable through X-propagation; recover to zero.
                        count_d = '0;
                    end else if (count_q == MAX_VAL) begin
                        ovf_d = 1'b1;
                        if (sat_l) begin
                            count_d = '0;
                            carry_d = 1'b1;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        ovf_d = 1'b1;
                        if (sat_l) begin
                            count_d = MAX_VAL;
                            carry_d = 1'b1;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_q <= '0;
            presc_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count     = count_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    // Terminal count tracks the live direction input, not a registered copy.
    assign tc        = up_dn ? (count_q == MAX_VAL) : (count_q == '0);
    assign count_tri = oe_l ? {WIDTH{1'bz}} : count_q;

endmodule

// File: tb/tb_count_mod_n.sv
// Bench for count_mod_n: three instances (4-bit mod 10, 4-bit mod 10 with
// prescale 3, 8-bit terminal 200) share one stimulus bus; each directed step
// queues its expected post-edge state and a negedge monitor checks it.
module tb_count_mod_n;

    logic       clk = 1'b0;
    logic       rst_l, load_l, enable_l, up_dn, sat_l, oe_l;
    logic [7:0] cnt_in;

    logic [3:0] count_a, tri_a, count_b, tri_b;
    logic [7:0] count_c, tri_c;
    logic       tc_a, carry_a, ovf_a;
    logic       tc_b, carry_b, ovf_b;
    logic       tc_c, carry_c, ovf_c;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         dut;
        logic [7:0] cnt;
        logic       carry;
        logic       ovf;
        logic       tc;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    count_mod_n #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1)) u_a (
        .clk(clk), .rst_l(rst_l), .load_l(load_l), .enable_l(enable_l),
        .up_dn(up_dn), .sat_l(sat_l), .cnt_in(cnt_in[3:0]), .oe_l(oe_l),
        .count(count_a), .count_tri(tri_a), .tc(tc_a), .carry(carry_a), .ovf(ovf_a));

    count_mod_n #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(3)) u_b (
        .clk(clk), .rst_l(rst_l), .load_l(load_l), .enable_l(enable_l),
        .up_dn(up_dn), .sat_l(sat_l), .cnt_in(cnt_in[3:0]), .oe_l(oe_l),
        .count(count_b), .count_tri(tri_b), .tc(tc_b), .carry(carry_b), .ovf(ovf_b));

    count_mod_n #(.WIDTH(8), .MAX_VAL(8'd200), .PRESCALE(1)) u_c (
        .clk(clk), .rst_l(rst_l), .load_l(load_l), .enable_l(enable_l),
        .up_dn(up_dn), .sat_l(sat_l), .cnt_in(cnt_in), .oe_l(oe_l),
        .count(count_c), .count_tri(tri_c), .tc(tc_c), .carry(carry_c), .ovf(ovf_c));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every negedge, compare each queued expectation against its DUT.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.dut)
                0: begin
                    chk({mon_e.name, ".count"}, {4'h0, count_a}, mon_e.cnt);
                    chk({mon_e.name, ".carry"}, {7'h0, carry_a}, {7'h0, mon_e.carry});
                    chk({mon_e.name, ".ovf"},   {7'h0, ovf_a},   {7'h0, mon_e.ovf});
                    chk({mon_e.name, ".tc"},    {7'h0, tc_a},    {7'h0, mon_e.tc});
                end
                1: begin
                    chk({mon_e.name, ".count"}, {4'h0, count_b}, mon_e.cnt);
                    chk({mon_e.name, ".carry"}, {7'h0, carry_b}, {7'h0, mon_e.carry});
                    chk({mon_e.name, ".ovf"},   {7'h0, ovf_b},   {7'h0, mon_e.ovf});
                    chk({mon_e.name, ".tc"},    {7'h0, tc_b},    {7'h0, mon_e.tc});
                end
                default: begin
                    chk({mon_e.name, ".count"}, count_c,         mon_e.cnt);
                    chk({mon_e.name, ".carry"}, {7'h0, carry_c}, {7'h0, mon_e.carry});
                    chk({mon_e.name, ".ovf"},   {7'h0, ovf_c},   {7'h0, mon_e.ovf});
                    chk({mon_e.name, ".tc"},    {7'h0, tc_c},    {7'h0, mon_e.tc});
                end
            endcase
            $display("txn %s dut=%0d exp_count=%0d exp_carry=%0d exp_ovf=%0d exp_tc=%0d",
                     mon_e.name, mon_e.dut, mon_e.cnt, mon_e.carry, mon_e.ovf, mon_e.tc);
        end
    end

    // Drive one cycle of inputs, then queue the state expected after the edge.
    task automatic step(input int dut, input logic ld, input logic en, input logic up,
                        input logic sat, input logic [7:0] cin, input logic [7:0] ecnt,
                        input logic ecarry, input logic eovf, input string name);
        exp_t       e;
        logic [7:0] mx;
        load_l   = ld;
        enable_l = en;
        up_dn    = up;
        sat_l    = sat;
        cnt_in   = cin;
        @(posedge clk);
        mx      = (dut == 2) ? 8'd200 : 8'd9;
        e.dut   = dut;
        e.cnt   = ecnt;
        e.carry = ecarry;
        e.ovf   = eovf;
        e.tc    = up ? (ecnt == mx) : (ecnt == 8'd0);
        e.name  = name;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] zz;
        rst_l = 1'b0; load_l = 1'b1; enable_l = 1'b1; up_dn = 1'b1;
        sat_l = 1'b1; oe_l = 1'b0; cnt_in = 8'd0;
        #3;
        chk("rst.count_a", {4'h0, count_a}, 8'd0);
        chk("rst.count_b", {4'h0, count_b}, 8'd0);
        chk("rst.count_c", count_c, 8'd0);
        chk("rst.flags",   {2'b0, carry_a, ovf_a, carry_b, ovf_b, carry_c, ovf_c}, 8'd0);
        chk("rst.tc_a",    {7'h0, tc_a}, 8'd0);
        @(negedge clk); #1;
        rst_l = 1'b1;

        // Up count, wrap mode, from reset: 1..9 then 0 with carry and ovf.
        for (int k = 1; k <= 10; k++) begin
            step(0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'(k % 10), k == 10, k == 10, "up_wrap");
            if (k == 5) begin
                oe_l = 1'b1; #1;
                zz = {4'h0, 4'bzzzz};
                chk("tri.off", {4'h0, tri_a}, zz);
                oe_l = 1'b0; #1;
                chk("tri.on", {4'h0, tri_a}, 8'd5);
            end
        end
        // Asynchronous reset between edges clears count, carry and ovf at once.
        rst_l = 1'b0; #1;
        chk("async_rst.count", {4'h0, count_a}, 8'd0);
        chk("async_rst.carry", {7'h0, carry_a}, 8'd0);
        chk("async_rst.ovf",   {7'h0, ovf_a},   8'd0);
        @(negedge clk); #1;
        rst_l = 1'b1;
        step(0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd1, 1'b0, 1'b0, "after_rst");

        // Saturate mode from 7: 8, 9, then hold at 9 with ovf, no carry.
        step(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd7, 8'd7, 1'b0, 1'b0, "sat_load");
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd8, 1'b0, 1'b0, "sat_t1");
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b0, "sat_t2");
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b1, "sat_t3");
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b1, "sat_t4");
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b1, "sat_t5");

        // Down, wrap mode: 1 -> 0 -> 9 with carry; clamped load clears ovf.
        step(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1,  8'd1, 1'b0, 1'b0, "dn_load");
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0, 1'b0, 1'b0, "dn_t1");
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0,  8'd9, 1'b1, 1'b1, "dn_wrap");
        step(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd15, 8'd9, 1'b0, 1'b0, "clamp");
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0,  8'd9, 1'b0, 1'b0, "tc_dir");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  8'd9, 1'b0, 1'b0, "dn_sat_hold");
        step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8'd0, 1'b0, 1'b0, "dn_sat_load0");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0, 1'b0, 1'b1, "dn_sat_floor");

        // Load beats enable in the same cycle.
        step(0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 8'd5, 1'b0, 1'b0, "ld_5");
        step(0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2, 1'b0, 1'b0, "ld_over_en");
        step(0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0, "ld_then_up");

        // Prescale 3: nine enabled cycles step on the 3rd, 6th and 9th.
        step(1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, "ps_load");
        for (int k = 1; k <= 9; k++)
            step(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'(k / 3), 1'b0, 1'b0, "ps_run");
        // Pause mid-prescale: prescaler holds, step comes 3 enabled cycles later.
        step(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0, "ps_e1");
        step(1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0, "ps_hold1");
        step(1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0, "ps_hold2");
        step(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0, "ps_e2");
        step(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd4, 1'b0, 1'b0, "ps_e3");
        // Load with enable mid-prescale restarts the prescaler from zero.
        step(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd4, 1'b0, 1'b0, "ps_pre");
        step(1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2, 1'b0, 1'b0, "ps_ld");
        step(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd2, 1'b0, 1'b0, "ps_r1");
        step(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd2, 1'b0, 1'b0, "ps_r2");
        step(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0, "ps_r3");

        // 8-bit, terminal 200: 199 -> 200 -> 0 with carry -> 1.
        step(2, 1'b0, 1'b1, 1'b1, 1'b1, 8'd199, 8'd199, 1'b0, 1'b0, "w8_load");
        step(2, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0,   8'd200, 1'b0, 1'b0, "w8_max");
        step(2, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   1'b1, 1'b1, "w8_wrap");
        step(2, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0,   8'd1,   1'b0, 1'b1, "w8_next");
        oe_l = 1'b0; #1;
        chk("tri8.on", tri_c, 8'd1);
        oe_l = 1'b1; #1;
        zz = 8'bzzzzzzzz;
        chk("tri8.off", tri_c, zz);

        enable_l = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
